// File: rtl/iqmap_multimode.sv
// Multi-mode IQ mapper: slices payload words MSB-first into 1/2/4/6-bit symbols
// and maps each one to Gray-coded BPSK/QPSK/16QAM/64QAM I/Q levels.
module iqmap_multimode #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 11
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ce,
    input  logic [1:0]       mode,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] xr,
    output logic [OUT_W-1:0] xi,
    output logic [5:0]       raw
);
    localparam int BUF_W = IN_W + 6;
    localparam int CNT_W = $clog2(IN_W + 6);
    localparam int FS    = 2 ** (OUT_W - 1) - 1;

    // Level tables packed as 8 OUT_W-bit entries; entry n is the level for binary index n.
    function automatic logic [8*OUT_W-1:0] build_levels(input int m);
        logic [8*OUT_W-1:0] t;
        int span;
        int q;
        int lvl;
        t    = '0;
        span = 2 ** m - 1;
        for (int n = 0; n < 2 ** m; n++) begin
            q   = (2 * n * (2 * FS + 1) + span) / (2 * span);
            lvl = FS - q;
            t[n*OUT_W +: OUT_W] = lvl[OUT_W-1:0];
        end
        return t;
    endfunction

    localparam logic [8*OUT_W-1:0] LV1 = build_levels(1);
    localparam logic [8*OUT_W-1:0] LV2 = build_levels(2);
    localparam logic [8*OUT_W-1:0] LV3 = build_levels(3);

    function automatic logic [OUT_W-1:0] pick(input logic [8*OUT_W-1:0] tbl, input logic [2:0] n);
        return tbl[n*OUT_W +: OUT_W];
    endfunction

    logic [BUF_W-1:0] bits, bits_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, k_c;
    logic [1:0]       mode_r;
    logic             flush_pend;
    logic [2:0]       k;
    logic [5:0]       top6, sym;
    logic             accept, pad, pop;
    logic [OUT_W-1:0] xr_n, xi_n;

    always_comb begin
        unique case (mode_r)
            2'd0:    k = 3'd1;
            2'd1:    k = 3'd2;
            2'd2:    k = 3'd4;
            default: k = 3'd6;
        endcase
    end

    assign k_c      = CNT_W'(k);
    assign in_ready = RST & ce & (cnt < k_c) & ~flush_pend;
    assign accept   = in_valid & in_ready;
    assign pad      = flush_pend & (cnt != '0) & (cnt < k_c);
    assign pop      = ce & ((cnt >= k_c) | pad) & (~out_valid | out_ready);
    assign top6     = bits[BUF_W-1 -: 6];
    // Bits below cnt are always zero, so a padded pop picks up zero LSBs for free.
    assign sym      = top6 >> (3'd6 - k);

    // NOTE: every variable in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        bits_nx = bits;
        cnt_nx  = cnt;
        if (accept) begin
            bits_nx = bits | ({in_data, 6'b0} >> cnt);
            cnt_nx  = cnt + CNT_W'(IN_W);
        end else if (pop) begin
            bits_nx = bits << k;
            cnt_nx  = pad ? '0 : cnt - k_c;
        end
    end

    // I takes the odd-position symbol bits from the MSB down, Q the even ones; Gray -> binary inline.
    always_comb begin
        xr_n = '0;
        xi_n = '0;
        unique case (mode_r)
            2'd0: xr_n = pick(LV1, {2'b0, sym[0]});
            2'd1: begin
                xr_n = pick(LV1, {2'b0, sym[1]});
                xi_n = pick(LV1, {2'b0, sym[0]});
            end
            2'd2: begin
                xr_n = pick(LV2, {1'b0, sym[3], sym[3] ^ sym[1]});
                xi_n = pick(LV2, {1'b0, sym[2], sym[2] ^ sym[0]});
            end
            default: begin
                xr_n = pick(LV3, {sym[5], sym[5] ^ sym[3], sym[5] ^ sym[3] ^ sym[1]});
                xi_n = pick(LV3, {sym[4], sym[4] ^ sym[2], sym[4] ^ sym[2] ^ sym[0]});
            end
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            bits       <= '0;
            cnt        <= '0;
            mode_r     <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            xr         <= '0;
            xi         <= '0;
            raw        <= '0;
        end else if (ce) begin
            bits       <= bits_nx;
            cnt        <= cnt_nx;
            flush_pend <= (flush_pend | (flush & (cnt != '0))) & (cnt_nx != '0);
            if (cnt == '0 && !accept)
                mode_r <= mode;
            if (pop) begin
                out_valid <= 1'b1;
                xr        <= xr_n;
                xi        <= xi_n;
                raw       <= sym;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_iqmap_multimode.sv
// Directed bench for iqmap_multimode: each task drives one scenario and checks
// hand-computed symbols captured by a handshake monitor.
module tb_iqmap_multimode;
    localparam int IN_W  = 128;
    localparam int OUT_W = 11;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             ce = 1'b1;
    logic [1:0]       mode = 2'd0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OUT_W-1:0] xr, xi;
    logic [5:0]       raw;

    typedef struct { int xr; int xi; int raw; } sym_t;
    sym_t q[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    iqmap_multimode #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .CLK(CLK), .RST(RST), .ce(ce), .mode(mode), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .xr(xr), .xi(xi), .raw(raw)
    );

    always @(posedge CLK) begin
        sym_t s;
        if (RST && ce && out_valid && out_ready) begin
            s.xr  = $signed(xr);
            s.xi  = $signed(xi);
            s.raw = int'(raw);
            q.push_back(s);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [IN_W-1:0] d, output bit ok);
        int c = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && c < 300) begin
            tick();
            c++;
        end
        ok = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_syms(input int n, output bit ok);
        int c = 0;
        while (q.size() < n && c < 3000) begin
            tick();
            c++;
        end
        ok = (q.size() >= n);
    endtask

    task automatic test_reset;
        RST = 1'b0;
        tick(2);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (xr !== '0 || xi !== '0 || raw !== '0) begin n_errors++; $display("FAIL reset_outputs: got xr=%0h xi=%0h raw=%0h expected 0", xr, xi, raw); end
        RST = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        tick();
    endtask

    task automatic test_qam16;
        bit ok;
        int bad = 0;
        mode = 2'd2;
        tick();
        q.delete();
        send_word({12'h0F8, 116'b0}, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL qam16_accept: got not ready expected ready"); end
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_errors++; $display("FAIL qam16_after_accept: got out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL qam16_latency: got out_valid=%b expected 1", out_valid); end
        wait_syms(32, ok);
        tick(3);
        n_checks++; if (q.size() != 32) begin n_errors++; $display("FAIL qam16_count: got %0d expected 32", q.size()); end
        n_checks++; if (q[0].xr !== 1023 || q[0].xi !== 1023 || q[0].raw !== 0) begin n_errors++; $display("FAIL qam16_sym0: got (%0d,%0d,%0h) expected (1023,1023,0)", q[0].xr, q[0].xi, q[0].raw); end
        n_checks++; if (q[1].xr !== -342 || q[1].xi !== -342 || q[1].raw !== 15) begin n_errors++; $display("FAIL qam16_sym1: got (%0d,%0d,%0h) expected (-342,-342,f)", q[1].xr, q[1].xi, q[1].raw); end
        n_checks++; if (q[2].xr !== -1024 || q[2].xi !== 1023 || q[2].raw !== 8) begin n_errors++; $display("FAIL qam16_sym2: got (%0d,%0d,%0h) expected (-1024,1023,8)", q[2].xr, q[2].xi, q[2].raw); end
        for (int i = 3; i < q.size(); i++)
            if (q[i].xr !== 1023 || q[i].xi !== 1023 || q[i].raw !== 0) bad++;
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL qam16_tail: got %0d bad symbols expected 0", bad); end
        n_checks++; if (in_ready !== 1'b1 || dut.cnt !== 0) begin n_errors++; $display("FAIL qam16_drained: got in_ready=%b cnt=%0d expected 1 0", in_ready, dut.cnt); end
    endtask

    task automatic test_qam64;
        bit ok;
        mode = 2'd3;
        tick();
        q.delete();
        send_word({6'h3F, 6'h00, 114'b0, 2'b10}, ok);
        wait_syms(21, ok);
        tick(3);
        n_checks++; if (q.size() != 21) begin n_errors++; $display("FAIL qam64_count1: got %0d expected 21", q.size()); end
        n_checks++; if (q[0].xr !== -439 || q[0].xi !== -439 || q[0].raw !== 63) begin n_errors++; $display("FAIL qam64_sym0: got (%0d,%0d,%0h) expected (-439,-439,3f)", q[0].xr, q[0].xi, q[0].raw); end
        n_checks++; if (q[1].xr !== 1023 || q[1].xi !== 1023 || q[1].raw !== 0) begin n_errors++; $display("FAIL qam64_sym1: got (%0d,%0d,%0h) expected (1023,1023,0)", q[1].xr, q[1].xi, q[1].raw); end
        n_checks++; if (dut.cnt !== 2 || in_ready !== 1'b1) begin n_errors++; $display("FAIL qam64_residual: got cnt=%0d in_ready=%b expected 2 1", dut.cnt, in_ready); end
        send_word({4'b0111, 124'b0}, ok);
        send_word('0, ok);
        wait_syms(64, ok);
        tick(3);
        n_checks++; if (q.size() != 64) begin n_errors++; $display("FAIL qam64_count3: got %0d expected 64", q.size()); end
        n_checks++; if (q[21].xr !== -732 || q[21].xi !== 438 || q[21].raw !== 39) begin n_errors++; $display("FAIL qam64_carry: got (%0d,%0d,%0h) expected (-732,438,27)", q[21].xr, q[21].xi, q[21].raw); end
        n_checks++; if (dut.cnt !== 0) begin n_errors++; $display("FAIL qam64_end_cnt: got %0d expected 0", dut.cnt); end
    endtask

    task automatic test_flush;
        bit ok;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (dut.flush_pend !== 1'b0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL flush_noop: got pend=%b in_ready=%b expected 0 1", dut.flush_pend, in_ready); end
        q.delete();
        send_word({126'b0, 2'b10}, ok);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_syms(22, ok);
        tick(3);
        n_checks++; if (q.size() != 22) begin n_errors++; $display("FAIL flush_count: got %0d expected 22", q.size()); end
        n_checks++; if (q[20].xr !== 1023 || q[20].xi !== 1023 || q[20].raw !== 0) begin n_errors++; $display("FAIL flush_last_normal: got (%0d,%0d,%0h) expected (1023,1023,0)", q[20].xr, q[20].xi, q[20].raw); end
        n_checks++; if (q[21].xr !== -1024 || q[21].xi !== 1023 || q[21].raw !== 32) begin n_errors++; $display("FAIL flush_padded: got (%0d,%0d,%0h) expected (-1024,1023,20)", q[21].xr, q[21].xi, q[21].raw); end
        n_checks++; if (dut.cnt !== 0 || in_ready !== 1'b1 || dut.flush_pend !== 1'b0) begin n_errors++; $display("FAIL flush_end: got cnt=%0d in_ready=%b pend=%b expected 0 1 0", dut.cnt, in_ready, dut.flush_pend); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int bad = 0;
        logic [OUT_W-1:0] hxr, hxi;
        logic [5:0] hraw;
        mode = 2'd1;
        tick();
        q.delete();
        out_ready = 1'b0;
        send_word({2'b01, 126'b0}, ok);
        tick();
        n_checks++; if (out_valid !== 1'b1 || $signed(xr) !== 1023 || $signed(xi) !== -1024 || raw !== 6'd1) begin n_errors++; $display("FAIL bp_first: got v=%b (%0d,%0d,%0h) expected 1 (1023,-1024,1)", out_valid, $signed(xr), $signed(xi), raw); end
        hxr = xr; hxi = xi; hraw = raw;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (xr !== hxr || xi !== hxi || raw !== hraw || out_valid !== 1'b1 || dut.cnt !== 126) bad++;
        end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
        out_ready = 1'b1;
        wait_syms(64, ok);
        tick(3);
        n_checks++; if (q.size() != 64) begin n_errors++; $display("FAIL bp_count: got %0d expected 64", q.size()); end
        n_checks++; if (q[0].xr !== 1023 || q[0].xi !== -1024 || q[0].raw !== 1) begin n_errors++; $display("FAIL bp_sym0: got (%0d,%0d,%0h) expected (1023,-1024,1)", q[0].xr, q[0].xi, q[0].raw); end
        n_checks++; if (q[1].xr !== 1023 || q[1].xi !== 1023 || q[1].raw !== 0) begin n_errors++; $display("FAIL bp_sym1: got (%0d,%0d,%0h) expected (1023,1023,0)", q[1].xr, q[1].xi, q[1].raw); end
    endtask

    task automatic test_mode_switch;
        bit ok;
        int bad = 0;
        mode = 2'd2;
        tick();
        q.delete();
        send_word({4'h8, 124'b0}, ok);
        tick(4);
        mode = 2'd0;
        tick();
        n_checks++; if (dut.mode_r !== 2'd2) begin n_errors++; $display("FAIL mode_ignored: got %0d expected 2", dut.mode_r); end
        wait_syms(32, ok);
        tick(3);
        n_checks++; if (q.size() != 32) begin n_errors++; $display("FAIL mode_count16: got %0d expected 32", q.size()); end
        n_checks++; if (q[0].xr !== -1024 || q[0].xi !== 1023 || q[0].raw !== 8) begin n_errors++; $display("FAIL mode_sym0: got (%0d,%0d,%0h) expected (-1024,1023,8)", q[0].xr, q[0].xi, q[0].raw); end
        for (int i = 1; i < q.size(); i++)
            if (q[i].xr !== 1023 || q[i].xi !== 1023 || q[i].raw !== 0) bad++;
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL mode_tail16: got %0d bad symbols expected 0", bad); end
        n_checks++; if (dut.mode_r !== 2'd0) begin n_errors++; $display("FAIL mode_loaded: got %0d expected 0", dut.mode_r); end
        q.delete();
        send_word({2'b10, 126'b0}, ok);
        wait_syms(128, ok);
        tick(3);
        n_checks++; if (q.size() != 128) begin n_errors++; $display("FAIL bpsk_count: got %0d expected 128", q.size()); end
        n_checks++; if (q[0].xr !== -1024 || q[0].xi !== 0 || q[0].raw !== 1) begin n_errors++; $display("FAIL bpsk_sym0: got (%0d,%0d,%0h) expected (-1024,0,1)", q[0].xr, q[0].xi, q[0].raw); end
        n_checks++; if (q[1].xr !== 1023 || q[1].xi !== 0 || q[1].raw !== 0) begin n_errors++; $display("FAIL bpsk_sym1: got (%0d,%0d,%0h) expected (1023,0,0)", q[1].xr, q[1].xi, q[1].raw); end
    endtask

    task automatic test_ce_reset;
        bit ok;
        int bad = 0;
        int n;
        int hcnt;
        logic [OUT_W-1:0] hxr, hxi;
        logic [5:0] hraw;
        mode = 2'd2;
        tick();
        q.delete();
        send_word({8'hF8, 120'b0}, ok);
        tick(3);
        ce = 1'b0;
        #1;
        hxr = xr; hxi = xi; hraw = raw; hcnt = int'(dut.cnt); n = q.size();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (xr !== hxr || xi !== hxi || raw !== hraw || out_valid !== 1'b1 || dut.cnt !== hcnt || in_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0 || q.size() != n) begin n_errors++; $display("FAIL ce_freeze: got %0d changed cycles, %0d new symbols expected 0 0", bad, q.size() - n); end
        ce = 1'b1;
        tick(2);
        RST = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || dut.cnt !== 0) begin n_errors++; $display("FAIL midreset: got out_valid=%b in_ready=%b cnt=%0d expected 0 0 0", out_valid, in_ready, dut.cnt); end
        n = q.size();
        RST = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL midreset_release: got in_ready=%b expected 1", in_ready); end
        tick(5);
        n_checks++; if (q.size() != n || out_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_no_emit: got %0d new symbols out_valid=%b expected 0 0", q.size() - n, out_valid); end
        ce = 1'b0;
        in_data = '1;
        in_valid = 1'b1;
        tick(3);
        in_valid = 1'b0;
        ce = 1'b1;
        n_checks++; if (dut.cnt !== 0) begin n_errors++; $display("FAIL ce_no_accept: got cnt=%0d expected 0", dut.cnt); end
    endtask

    initial begin
        test_reset();
        test_qam16();
        test_qam64();
        test_flush();
        test_backpressure();
        test_mode_switch();
        test_ce_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
